stack_tower: RTL



---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_move_ctrl.sv | 39 +++
 rtl/stack_tower.sv | 121 ++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stacking-tower game block: FSM states,
// colour codes and screen geometry.
package stack_pkg;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_CAUGHT = 2'd1,
        ST_MISSED = 2'd2,
        ST_WAIT   = 2'd3
    } tower_state_t;

    localparam logic [1:0] CLR_NONE  = 2'd0;
    localparam logic [1:0] CLR_RED   = 2'd1;
    localparam logic [1:0] CLR_GREEN = 2'd2;
    localparam logic [1:0] CLR_BLUE  = 2'd3;

    localparam int SCREEN_W = 640;
    localparam int COORD_W  = 10;

endpackage

// File: rtl/stack_move_ctrl.sv
// Horizontal position of the stack: free-running tick divider plus a
// clamped one-pixel-per-tick x register.
module stack_move_ctrl
    import stack_pkg::*;
#(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 490,
    parameter int X_RESET    = 300,
    parameter int MOVE_DIV_W = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left,
    input  logic       right,
    output logic [9:0] x
);

    // The right clamp never lets the stack leave the visible screen.
    localparam int X_HI = (X_MAX < SCREEN_W) ? X_MAX : SCREEN_W - 1;

    logic [MOVE_DIV_W-1:0] div;
    logic                  step;

    assign step = (div == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            x   <= 10'(X_RESET);
        end else begin
            div <= div + MOVE_DIV_W'(1);
            if (step && left && !right && (x > 10'(X_MIN)))
                x <= x - 10'd1;
            else if (step && right && !left && (x < 10'(X_HI)))
                x <= x + 10'd1;
        end
    end

endmodule

// File: rtl/stack_tower.sv
// Stacking tower: catches falling blocks onto a movable stack and keeps
// the colour history. Define STACK_TOWER_TOPPLE_EN to lose the top block on a miss.
module stack_tower
    import stack_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int COLOR_W    = 2,
    parameter int BASE_Y     = 400,
    parameter int BLOCK_H    = 20,
    parameter int LEEWAY     = 15,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 490,
    parameter int X_RESET    = 300,
    parameter int MOVE_DIV_W = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       left,
    input  logic                       right,
    input  logic                       fall_valid,
    input  logic [9:0]                 fall_x,
    input  logic [9:0]                 fall_y,
    input  logic [COLOR_W-1:0]         fall_color,
    output logic [9:0]                 pos_x,
    output logic [9:0]                 pos_y,
    output logic [$clog2(DEPTH+1)-1:0] height,
    output logic [DEPTH*COLOR_W-1:0]   colors,
    output logic                       catch_pulse,
    output logic                       miss_pulse,
    output logic                       full
);

    localparam int HW = $clog2(DEPTH + 1);
    localparam int CW = DEPTH * COLOR_W;
    localparam logic [HW-1:0]     H_ONE    = HW'(1);
    localparam logic [HW-1:0]     H_FULL   = HW'(DEPTH);
    localparam logic signed [10:0] LEEWAY_S = 11'(LEEWAY);
    localparam logic [10:0]       MISS_Y   = 11'(BASE_Y + LEEWAY);

    tower_state_t        state, state_nxt;
    logic [COLOR_W-1:0]  held_color;
    logic signed [10:0]  dx, dy, adx, ady;
    logic                hit, miss;

    stack_move_ctrl #(
        .X_MIN      (X_MIN),
        .X_MAX      (X_MAX),
        .X_RESET    (X_RESET),
        .MOVE_DIV_W (MOVE_DIV_W)
    ) u_move (
        .clk   (clk),
        .rst_n (rst_n),
        .left  (left),
        .right (right),
        .x     (pos_x)
    );

    assign pos_y = 10'(BASE_Y) - 10'(int'(height) * BLOCK_H);
    assign full  = (height == H_FULL);

    // Zero-extended 11-bit differences so a far-away object never wraps into range.
    assign dx   = $signed({1'b0, fall_x}) - $signed({1'b0, pos_x});
    assign dy   = $signed({1'b0, fall_y}) - $signed({1'b0, pos_y});
    assign adx  = dx[10] ? -dx : dx;
    assign ady  = dy[10] ? -dy : dy;
    assign hit  = (adx < LEEWAY_S) && (ady < LEEWAY_S);
    assign miss = ({1'b0, fall_y} > MISS_Y) && !hit;

    always_comb begin
        state_nxt   = state;
        catch_pulse = 1'b0;
        miss_pulse  = 1'b0;
        unique case (state)
            ST_ARMED: begin
                if (fall_valid && hit)
                    state_nxt = ST_CAUGHT;
                else if (fall_valid && miss)
                    state_nxt = ST_MISSED;
            end
            ST_CAUGHT: begin
                catch_pulse = 1'b1;
                state_nxt   = ST_WAIT;
            end
            ST_MISSED: begin
                miss_pulse = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!fall_valid)
                    state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_ARMED;
        endcase
    end

    // The colour is captured at detection so the push does not depend on the
    // falling object still being presented during the CAUGHT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ARMED;
            height     <= '0;
            colors     <= '0;
            held_color <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_ARMED) && fall_valid && hit)
                held_color <= fall_color;
            if ((state == ST_CAUGHT) && !full) begin
                height <= height + H_ONE;
                colors <= (colors << COLOR_W) | CW'(held_color);
            end
`ifdef STACK_TOWER_TOPPLE_EN
            if ((state == ST_MISSED) && (height != '0)) begin
                height <= height - H_ONE;
                colors <= colors >> COLOR_W;
            end
`endif
        end
    end

endmodule
